// File: rtl/nebula_pkg.sv
// Shared mesh types: flit layout, packet kinds, mesh geometry and responder FSM states.
package nebula_pkg;

    localparam int MESH_SIZE_X = 4;
    localparam int MESH_SIZE_Y = 4;
    localparam int COORD_W     = 2;
    localparam int SEQ_W       = 8;
    localparam int DATA_W      = 32;

    typedef enum logic [1:0] {
        PACKET_DATA = 2'd0,
        PACKET_CTRL = 2'd1,
        PACKET_RESP = 2'd2
    } packet_type_t;

    typedef enum logic [1:0] {
        RESP_IDLE = 2'd0,
        RESP_WAIT = 2'd1,
        RESP_SEND = 2'd2
    } resp_state_t;

    typedef struct packed {
        logic                valid;
        packet_type_t        packet_type;
        logic [COORD_W-1:0]  src_x;
        logic [COORD_W-1:0]  src_y;
        logic [COORD_W-1:0]  dest_x;
        logic [COORD_W-1:0]  dest_y;
        logic [SEQ_W-1:0]    sequence_num;
        logic [DATA_W-1:0]   data;
    } flit_t;

    // Turn a request around: reply goes back to its sender with inverted payload.
    function automatic flit_t make_resp(input flit_t req,
                                        input logic [COORD_W-1:0] my_x,
                                        input logic [COORD_W-1:0] my_y);
        flit_t rsp;
        rsp.valid        = 1'b1;
        rsp.packet_type  = PACKET_RESP;
        rsp.src_x        = my_x;
        rsp.src_y        = my_y;
        rsp.dest_x       = req.src_x;
        rsp.dest_y       = req.src_y;
        rsp.sequence_num = req.sequence_num;
        rsp.data         = ~req.data;
        return rsp;
    endfunction

endpackage

// File: rtl/nebula_resp_fifo.sv
// Pending-request queue of flits; pointers carry a wrap bit to tell full from empty.
module nebula_resp_fifo
    import nebula_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_push,
    input  flit_t i_push_data,
    input  logic  i_pop,
    output logic  o_full,
    output logic  o_empty,
    output flit_t o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    flit_t         r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    // Storage array, deliberately without reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    // Read and write pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/nebula_node_responder.sv
// Mesh endpoint answering local PACKET_DATA requests with PACKET_RESP flits.
// Optional per-source sequence checking is enabled by defining NEBULA_RESP_SEQ_CHECK_EN.
module nebula_node_responder
    import nebula_pkg::*;
#(
    parameter int MY_X         = 0,
    parameter int MY_Y         = 0,
    parameter int FIFO_DEPTH   = 4,
    parameter int RESP_LATENCY = 2
)(
    input  logic        clk,
    input  logic        rst_n,
    input  flit_t       i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output flit_t       o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic [31:0] o_req_count,
    output logic [31:0] o_resp_count,
    output logic [15:0] o_drop_count,
    output logic [15:0] o_seq_err_count,
    output logic        o_busy
);

    localparam logic [COORD_W-1:0] MY_X_C   = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] MY_Y_C   = COORD_W'(MY_Y);
    localparam bit                 ZERO_LAT = (RESP_LATENCY == 0);
    localparam logic [7:0]         LAT_M1   = ZERO_LAT ? 8'd0 : 8'(RESP_LATENCY - 1);

    resp_state_t r_state, w_state_nxt;
    logic [7:0]  r_wait_cnt, w_wait_cnt_nxt;
    flit_t       r_tx_data, w_tx_data_nxt;
    logic        r_tx_valid;
    logic [31:0] r_req_count, r_resp_count;
    logic [15:0] r_drop_count;
    logic        w_fifo_full, w_fifo_empty, w_pop, w_resp_done;
    logic        w_rx_hs, w_accept, w_drop;
    flit_t       w_fifo_head;

    assign w_rx_hs  = i_rx_valid && o_rx_ready;
    assign w_accept = w_rx_hs && i_rx_data.valid && (i_rx_data.packet_type == PACKET_DATA) &&
                      (i_rx_data.dest_x == MY_X_C) && (i_rx_data.dest_y == MY_Y_C);
    assign w_drop   = w_rx_hs && !w_accept;

    nebula_resp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_accept),
        .i_push_data (i_rx_data),
        .i_pop       (w_pop),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_head      (w_fifo_head)
    );

    // Responder next-state: pop into the hold register, wait out the latency, present until accepted.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_tx_data_nxt  = r_tx_data;
        w_pop          = 1'b0;
        w_resp_done    = 1'b0;
        case (r_state)
            RESP_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop         = 1'b1;
                    w_tx_data_nxt = make_resp(w_fifo_head, MY_X_C, MY_Y_C);
                    if (ZERO_LAT) begin
                        w_state_nxt = RESP_SEND;
                    end else begin
                        w_wait_cnt_nxt = LAT_M1;
                        w_state_nxt    = RESP_WAIT;
                    end
                end else begin
                    w_state_nxt = RESP_IDLE;
                end
            end
            RESP_WAIT: begin
                if (r_wait_cnt == 8'd0) begin
                    w_state_nxt = RESP_SEND;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 8'd1;
                end
            end
            RESP_SEND: begin
                if (i_tx_ready) begin
                    w_resp_done = 1'b1;
                    w_state_nxt = RESP_IDLE;
                end else begin
                    w_state_nxt = RESP_SEND;
                end
            end
            default: begin
                w_state_nxt = RESP_IDLE;
            end
        endcase
    end

    // FSM state, wait counter and registered tx interface.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= RESP_IDLE;
            r_wait_cnt <= 8'd0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= (w_state_nxt == RESP_SEND);
        end
    end

    // Traffic counters; the drop counter saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_count  <= 32'd0;
            r_resp_count <= 32'd0;
            r_drop_count <= 16'd0;
        end else begin
            if (w_accept) begin
                r_req_count <= r_req_count + 32'd1;
            end
            if (w_resp_done) begin
                r_resp_count <= r_resp_count + 32'd1;
            end
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

`ifdef NEBULA_RESP_SEQ_CHECK_EN
    localparam int N_SRC = MESH_SIZE_X * MESH_SIZE_Y;
    localparam int IDX_W = $clog2(N_SRC);

    logic [N_SRC-1:0] r_seen;
    logic [SEQ_W-1:0] r_last [N_SRC];
    logic [15:0]      r_seq_err;
    logic [IDX_W-1:0] w_src_idx;
    logic [SEQ_W-1:0] w_seq_exp;
    logic             w_seq_bad;

    assign w_src_idx = IDX_W'(int'(i_rx_data.src_y) * MESH_SIZE_X + int'(i_rx_data.src_x));
    assign w_seq_exp = r_last[w_src_idx] + SEQ_W'(1);
    assign w_seq_bad = w_accept && r_seen[w_src_idx] && (i_rx_data.sequence_num != w_seq_exp);

    // Last sequence number per source; only meaningful once the seen bit is set.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_last[w_src_idx] <= i_rx_data.sequence_num;
        end
    end

    // Seen bits and saturating sequence-error counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seen    <= '0;
            r_seq_err <= 16'd0;
        end else begin
            if (w_accept) begin
                r_seen[w_src_idx] <= 1'b1;
            end
            if (w_seq_bad && (r_seq_err != 16'hFFFF)) begin
                r_seq_err <= r_seq_err + 16'd1;
            end
        end
    end

    assign o_seq_err_count = r_seq_err;
`else
    assign o_seq_err_count = 16'd0;
`endif

    assign o_rx_ready   = !w_fifo_full;
    assign o_tx_data    = r_tx_data;
    assign o_tx_valid   = r_tx_valid;
    assign o_req_count  = r_req_count;
    assign o_resp_count = r_resp_count;
    assign o_drop_count = r_drop_count;
    assign o_busy       = !w_fifo_empty || (r_state != RESP_IDLE);

endmodule

// File: tb/tb_nebula_node_responder.sv
// Directed bench: a latency-2 responder and a latency-0 responder, both at (2,1).
module tb_nebula_node_responder;
    import nebula_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    flit_t       a_rx_data, a_tx_data, b_rx_data, b_tx_data;
    logic        a_rx_valid, a_rx_ready, a_tx_valid, a_tx_ready, a_busy;
    logic        b_rx_valid, b_rx_ready, b_tx_valid, b_tx_ready, b_busy;
    logic [31:0] a_req_count, a_resp_count, b_req_count, b_resp_count;
    logic [15:0] a_drop_count, a_seq_err_count, b_drop_count, b_seq_err_count;

    int    n_checks = 0;
    int    n_errors = 0;
    int    idx, ridx;
    logic  hs, saw, prev_v, prev_r;
    flit_t prev_d;
    flit_t q_req [6];
    flit_t q_exp [6];
    flit_t exp1;

`ifdef NEBULA_RESP_SEQ_CHECK_EN
    localparam logic [15:0] EXP_SEQ_ERR = 16'd1;
`else
    localparam logic [15:0] EXP_SEQ_ERR = 16'd0;
`endif

    nebula_node_responder #(.MY_X(2), .MY_Y(1), .FIFO_DEPTH(4), .RESP_LATENCY(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_rx_data(a_rx_data), .i_rx_valid(a_rx_valid), .o_rx_ready(a_rx_ready),
        .o_tx_data(a_tx_data), .o_tx_valid(a_tx_valid), .i_tx_ready(a_tx_ready),
        .o_req_count(a_req_count), .o_resp_count(a_resp_count),
        .o_drop_count(a_drop_count), .o_seq_err_count(a_seq_err_count), .o_busy(a_busy)
    );

    nebula_node_responder #(.MY_X(2), .MY_Y(1), .FIFO_DEPTH(4), .RESP_LATENCY(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_rx_data(b_rx_data), .i_rx_valid(b_rx_valid), .o_rx_ready(b_rx_ready),
        .o_tx_data(b_tx_data), .o_tx_valid(b_tx_valid), .i_tx_ready(b_tx_ready),
        .o_req_count(b_req_count), .o_resp_count(b_resp_count),
        .o_drop_count(b_drop_count), .o_seq_err_count(b_seq_err_count), .o_busy(b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic flit_t mk_req(input packet_type_t t, input logic [1:0] sx, input logic [1:0] sy,
                                     input logic [1:0] dx, input logic [1:0] dy,
                                     input logic [7:0] seq, input logic [31:0] d);
        flit_t f;
        f.valid = 1'b1; f.packet_type = t;
        f.src_x = sx; f.src_y = sy; f.dest_x = dx; f.dest_y = dy;
        f.sequence_num = seq; f.data = d;
        return f;
    endfunction

    function automatic flit_t exp_resp(input logic [1:0] sx, input logic [1:0] sy,
                                       input logic [7:0] seq, input logic [31:0] d);
        flit_t f;
        f.valid = 1'b1; f.packet_type = PACKET_RESP;
        f.src_x = 2'd2; f.src_y = 2'd1; f.dest_x = sx; f.dest_y = sy;
        f.sequence_num = seq; f.data = ~d;
        return f;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_rx_valid = 1'b0; a_rx_data = '0; a_tx_ready = 1'b1;
        b_rx_valid = 1'b0; b_rx_data = '0; b_tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_tx_valid", 64'(a_tx_valid), 64'd0);
        chk("rst_tx_data", 64'(a_tx_data), 64'd0);
        chk("rst_rx_ready", 64'(a_rx_ready), 64'd1);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_counts", {a_req_count, a_resp_count}, 64'd0);
        chk("rst_drop_seq", {32'd0, a_drop_count, a_seq_err_count}, 64'd0);
        rst_n = 1'b1;

        // Single request, latency 2: tx_valid first high after edge E+3
        a_rx_data  = mk_req(PACKET_DATA, 2'd0, 2'd3, 2'd2, 2'd1, 8'd5, 32'h0000_00FF);
        a_rx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_rx_valid = 1'b0;
        chk("lat_req_count", 64'(a_req_count), 64'd1);
        chk("lat_e0", 64'(a_tx_valid), 64'd0);
        @(negedge clk);
        chk("lat_e1", 64'(a_tx_valid), 64'd0);
        @(negedge clk);
        chk("lat_e2", 64'(a_tx_valid), 64'd0);
        @(negedge clk);
        chk("lat_e3", 64'(a_tx_valid), 64'd1);
        exp1.valid = 1'b1; exp1.packet_type = PACKET_RESP;
        exp1.src_x = 2'd2; exp1.src_y = 2'd1; exp1.dest_x = 2'd0; exp1.dest_y = 2'd3;
        exp1.sequence_num = 8'd5; exp1.data = 32'hFFFF_FF00;
        chk("lat_flit", 64'(a_tx_data), 64'(exp1));
        @(negedge clk);
        chk("lat_resp_count", 64'(a_resp_count), 64'd1);
        chk("lat_after_valid", 64'(a_tx_valid), 64'd0);
        chk("lat_busy", 64'(a_busy), 64'd0);

        // Drops: wrong destination, then a PACKET_RESP addressed to us
        do_reset();
        a_rx_data  = mk_req(PACKET_DATA, 2'd0, 2'd0, 2'd3, 2'd3, 8'd1, 32'h1234_5678);
        a_rx_valid = 1'b1;
        @(negedge clk);
        a_rx_data  = mk_req(PACKET_RESP, 2'd0, 2'd0, 2'd2, 2'd1, 8'd2, 32'h1234_5678);
        @(negedge clk);
        a_rx_valid = 1'b0;
        saw = 1'b0;
        repeat (6) begin
            if (a_tx_valid) saw = 1'b1;
            @(negedge clk);
        end
        chk("drop_no_tx", 64'(saw), 64'd0);
        chk("drop_count", 64'(a_drop_count), 64'd2);
        chk("drop_req_count", 64'(a_req_count), 64'd0);

        // Backpressure: 6 requests with tx_ready low, then release
        for (int i = 0; i < 6; i++) begin
            q_req[i] = mk_req(PACKET_DATA, 2'd1, 2'd0, 2'd2, 2'd1, 8'(10 + i), 32'(32'h1111_1111 * (i + 1)));
            q_exp[i] = exp_resp(2'd1, 2'd0, 8'(10 + i), 32'(32'h1111_1111 * (i + 1)));
        end
        do_reset();
        a_tx_ready = 1'b0;
        idx = 0; ridx = 0;
        for (int cyc = 0; cyc < 80 && !(idx == 6 && ridx == 6); cyc++) begin
            if (cyc == 10) begin
                chk("bp_stall_data_early", 64'(a_tx_data), 64'(q_exp[0]));
            end
            if (cyc == 20) begin
                chk("bp_accepted", 64'(idx), 64'd5);
                chk("bp_rx_ready_low", 64'(a_rx_ready), 64'd0);
                chk("bp_tx_valid_held", 64'(a_tx_valid), 64'd1);
                chk("bp_stall_data_late", 64'(a_tx_data), 64'(q_exp[0]));
                a_tx_ready = 1'b1;
            end
            if (a_tx_valid && a_tx_ready && ridx < 6) begin
                chk($sformatf("bp_resp%0d", ridx), 64'(a_tx_data), 64'(q_exp[ridx]));
                ridx++;
            end
            a_rx_valid = (idx < 6);
            if (idx < 6) a_rx_data = q_req[idx];
            hs = a_rx_valid && a_rx_ready;
            @(posedge clk);
            if (hs) idx++;
            @(negedge clk);
        end
        a_rx_valid = 1'b0;
        chk("bp_all_accepted", 64'(idx), 64'd6);
        chk("bp_all_responded", 64'(ridx), 64'd6);
        chk("bp_resp_count", 64'(a_resp_count), 64'd6);
        chk("bp_req_count", 64'(a_req_count), 64'd6);

        // Latency 0 with tx_ready toggling over 4 requests
        idx = 0; ridx = 0; prev_v = 1'b0; prev_r = 1'b0; prev_d = '0;
        for (int i = 0; i < 4; i++) begin
            q_req[i] = mk_req(PACKET_DATA, 2'd3, 2'd2, 2'd2, 2'd1, 8'(20 + i), 32'(32'hA5A5_0000 + i));
            q_exp[i] = exp_resp(2'd3, 2'd2, 8'(20 + i), 32'(32'hA5A5_0000 + i));
        end
        for (int cyc = 0; cyc < 60 && !(idx == 4 && ridx == 4); cyc++) begin
            b_tx_ready = (cyc % 2 == 0);
            if (prev_v && !prev_r) begin
                chk("z_hold_valid", 64'(b_tx_valid), 64'd1);
                chk("z_hold_data", 64'(b_tx_data), 64'(prev_d));
            end
            if (b_tx_valid && b_tx_ready && ridx < 4) begin
                chk($sformatf("z_resp%0d", ridx), 64'(b_tx_data), 64'(q_exp[ridx]));
                ridx++;
            end
            prev_v = b_tx_valid; prev_r = b_tx_ready; prev_d = b_tx_data;
            b_rx_valid = (idx < 4);
            if (idx < 4) b_rx_data = q_req[idx];
            hs = b_rx_valid && b_rx_ready;
            @(posedge clk);
            if (hs) idx++;
            @(negedge clk);
        end
        b_rx_valid = 1'b0;
        b_tx_ready = 1'b1;
        chk("z_responded", 64'(ridx), 64'd4);
        chk("z_resp_count", 64'(b_resp_count), 64'd4);
        chk("z_busy_drained", 64'(b_busy), 64'd0);

        // Reset while in WAIT with requests pending
        do_reset();
        a_tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_rx_data  = mk_req(PACKET_DATA, 2'd0, 2'd1, 2'd2, 2'd1, 8'(40 + i), 32'(i));
            a_rx_valid = 1'b1;
            @(negedge clk);
        end
        chk("mid_busy", 64'(a_busy), 64'd1);
        chk("mid_req_count", 64'(a_req_count), 64'd3);
        rst_n = 1'b0;
        a_rx_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_counts", {a_req_count, a_resp_count}, 64'd0);
        chk("mid_rst_drop", 64'(a_drop_count), 64'd0);
        chk("mid_rst_tx_valid", 64'(a_tx_valid), 64'd0);
        chk("mid_rst_rx_ready", 64'(a_rx_ready), 64'd1);
        chk("mid_rst_busy", 64'(a_busy), 64'd0);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (a_tx_valid) saw = 1'b1;
        end
        chk("mid_no_stale", 64'(saw), 64'd0);
        chk("mid_resp_count", 64'(a_resp_count), 64'd0);

        // Sequence check from source (1,1): 0,1,3,4
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q_req[i] = mk_req(PACKET_DATA, 2'd1, 2'd1, 2'd2, 2'd1, 8'(i < 2 ? i : i + 1), 32'(32'h0F0F_0000 + i));
            q_exp[i] = exp_resp(2'd1, 2'd1, 8'(i < 2 ? i : i + 1), 32'(32'h0F0F_0000 + i));
        end
        for (int i = 0; i < 4; i++) begin
            a_rx_data  = q_req[i];
            a_rx_valid = 1'b1;
            @(negedge clk);
        end
        a_rx_valid = 1'b0;
        ridx = 0;
        for (int cyc = 0; cyc < 40 && ridx < 4; cyc++) begin
            if (a_tx_valid) begin
                chk($sformatf("seq_resp%0d", ridx), 64'(a_tx_data), 64'(q_exp[ridx]));
                ridx++;
            end
            @(negedge clk);
        end
        chk("seq_responses", 64'(ridx), 64'd4);
        chk("seq_resp_count", 64'(a_resp_count), 64'd4);
        chk("seq_err_count", 64'(a_seq_err_count), 64'(EXP_SEQ_ERR));
        chk("seq_err_other", 64'(b_seq_err_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nebula_node_responder.md
Name: nebula_node_responder

Overview:
- Synthesizable endpoint that attaches to a router local port and answers every PACKET_DATA request addressed to it with one PACKET_RESP flit returned to the requester.
- Request flits arrive on the router's local_resp side (rx). Response flits are injected on the router's local_req side (tx).
- It is the responder counterpart to the mesh traffic initiators and lets system benches check round trips without a behavioural sink.

Parameters:
- MY_X, 0, X coordinate of the attached router; must match the router's MY_X_COORD.
- MY_Y, 0, Y coordinate of the attached router; must match the router's MY_Y_COORD.
- FIFO_DEPTH, 4, pending-request queue depth; power of 2, at least 2.
- RESP_LATENCY, 2, processing delay in cycles between FIFO pop and first tx_valid; range 0..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- rx_data  in  flit_t  request flit, from router local_resp_data
- rx_valid  in  1  from router local_resp_valid
- rx_ready  out  1  to router local_resp_ready
- tx_data  out  flit_t  response flit, to router local_req_data
- tx_valid  out  1  to router local_req_valid
- tx_ready  in  1  from router local_req_ready
- req_count  out  32  accepted valid requests; wraps
- resp_count  out  32  completed tx handshakes; wraps
- drop_count  out  16  discarded rx flits; saturates at 0xFFFF
- seq_err_count  out  16  sequence errors; see Optional Feature
- busy  out  1  high when the FIFO is non-empty or the FSM is not in IDLE

Behaviour:
- Reset values: all counters 0, tx_valid 0, tx_data all-zero, FIFO empty, FSM in IDLE, busy 0.
- rx_ready = !fifo_full, registered-state based. There is no bypass: a full FIFO keeps rx_ready low even in a cycle where it pops.
- An rx handshake (rx_valid && rx_ready) classifies the flit:
  - Accept and push: flit.valid==1, packet_type==PACKET_DATA, dest_x==MY_X, dest_y==MY_Y. req_count increments.
  - Any other flit (including an arriving PACKET_RESP): discard and increment drop_count, saturating.
- FSM states:
  - IDLE: when the FIFO is non-empty, pop the head into a hold register. If RESP_LATENCY==0 go to SEND; otherwise load the wait counter with RESP_LATENCY-1 and go to WAIT.
  - WAIT: decrement the counter. When it reaches 0, go to SEND.
  - SEND: drive tx_valid=1. On tx_ready, increment resp_count and go to IDLE. IDLE then pops the next entry on the following edge, so back-to-back throughput is 1 response per 2+RESP_LATENCY cycles.
- Latency: an rx handshake at edge E gives a first tx_valid high in the cycle after edge E+1+RESP_LATENCY.
- Response flit fields:
  - packet_type=PACKET_RESP
  - src_x/src_y = MY_X/MY_Y
  - dest_x/dest_y = request src_x/src_y
  - sequence_num copied from the request
  - data = bitwise NOT of the request data
  - valid=1
- tx_data and tx_valid stay stable while tx_valid && !tx_ready. tx_valid never drops without a handshake.
- Self-addressed request (src == MY): responded to normally; the router delivers the response locally.
- Simultaneous rx push and FSM pop: both happen, and the occupancy is unchanged.
- rst_n low mid-operation: queued and in-flight responses are lost. All outputs return to their reset values at the next edge.

Optional Feature:
- Macro: NEBULA_RESP_SEQ_CHECK_EN.
- Defined:
  - Per-source table, MESH_SIZE_X*MESH_SIZE_Y entries from nebula_pkg, each holding a seen bit and last sequence_num.
  - On an accepted request whose source is seen and whose sequence_num != last+1 (modulo field width), increment seq_err_count, saturating.
  - Update last on every accepted request; the first request from a source only sets seen.
  - Responses are generated regardless of seq errors.
- Undefined: no table; seq_err_count tied to 0.

Decomposition:
- nebula_pkg gains:
  - PACKET_RESP value in the packet type enum.
  - resp_state_t enum {RESP_IDLE, RESP_WAIT, RESP_SEND}.
- flit_t, MESH_SIZE_X and MESH_SIZE_Y stay in nebula_pkg.
- One sub-module: nebula_resp_fifo. Synchronous FIFO of flit_t; parameter DEPTH; ports push/pop/full/empty/head; storage not reset, pointers reset.

Test Plan:
- MY=(2,1), RESP_LATENCY=2, tx_ready=1. Send DATA src=(0,3), seq=5, data=0x0000_00FF, at edge E.
  - Expect tx_valid first high in the cycle after edge E+3.
  - Flit: RESP, src=(2,1), dest=(0,3), seq=5, data=0xFFFF_FF00.
  - req_count=1, resp_count=1.
- Send a flit with dest=(3,3), then a PACKET_RESP flit with dest=(2,1).
  - Expect no tx activity, drop_count=2, req_count=0.
- tx_ready=0; send 6 back-to-back requests, FIFO_DEPTH=4.
  - Expect 5 handshakes (4 in the FIFO, 1 in the hold register), then rx_ready low until tx_ready is raised.
  - Expect all 6 responses in order with tx_data stable while stalled.
- RESP_LATENCY=0 with tx_ready toggling 1/0/1 over 4 queued requests.
  - Expect responses only on handshake cycles; resp_count=4; busy low once drained.
- Assert rst_n for 1 cycle while in WAIT with 3 requests queued.
  - Expect all counters 0, tx_valid 0, rx_ready 1, and no stale response after release.
- With NEBULA_RESP_SEQ_CHECK_EN: from src (1,1), send seq 0,1,3,4.
  - Expect seq_err_count=1 and 4 responses.
  - Without the macro: seq_err_count=0.
